// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access controller.
// Contents: register address/data widths, arbiter state enum, write-buffer entry payload.
package regfile_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned REG_DATA_W = 32;

   // Which register-file access the arbiter grants in the current cycle
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_GRANT = 2'd1,
      ST_WR_GRANT = 2'd2
   } rf_state_e;

   // One pending writeback
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wbuf_entry_t;

endpackage

// File: rtl/regfile_ctrl_if.sv
// Bus bundle between requesters, the controller and the register file.
// Groups: writeback request (wr_*), operand read request (rd_*), read response (rsp_*),
// register-file side (rf_*).
// Modports: slave = controller, master = requester / register-file environment.
interface regfile_ctrl_if;
   import regfile_pkg::*;

   logic                  wr_valid;
   logic                  wr_ready;
   logic [REG_ADDR_W-1:0] wr_addr;
   logic [REG_DATA_W-1:0] wr_data;

   logic                  rd_valid;
   logic                  rd_ready;
   logic [REG_ADDR_W-1:0] rd_addr_a;
   logic [REG_ADDR_W-1:0] rd_addr_b;

   logic                  rsp_valid;
   logic [REG_DATA_W-1:0] rsp_data_a;
   logic [REG_DATA_W-1:0] rsp_data_b;

   logic                  rf_ld;
   logic [REG_ADDR_W-1:0] rf_sa;
   logic [REG_ADDR_W-1:0] rf_sb;
   logic [REG_ADDR_W-1:0] rf_dr;
   logic [REG_DATA_W-1:0] rf_d_in;
   logic [REG_DATA_W-1:0] rf_data_a;
   logic [REG_DATA_W-1:0] rf_data_b;

   modport slave (
      input  wr_valid, wr_addr, wr_data,
      input  rd_valid, rd_addr_a, rd_addr_b,
      input  rf_data_a, rf_data_b,
      output wr_ready, rd_ready,
      output rsp_valid, rsp_data_a, rsp_data_b,
      output rf_ld, rf_sa, rf_sb, rf_dr, rf_d_in
   );

   modport master (
      output wr_valid, wr_addr, wr_data,
      output rd_valid, rd_addr_a, rd_addr_b,
      output rf_data_a, rf_data_b,
      input  wr_ready, rd_ready,
      input  rsp_valid, rsp_data_a, rsp_data_b,
      input  rf_ld, rf_sa, rf_sb, rf_dr, rf_d_in
   );

endinterface

// File: rtl/regfile_ctrl_wbuf_fifo.sv
// wbuf_fifo: write buffer for pending register writebacks.
// Ports: clk, rst_n (async active-low); i_push/i_entry enqueue, i_pop dequeue,
// o_head oldest entry, o_full/o_empty status, o_ord_addr/o_ord_vld every entry in
// age order (index 0 = oldest) for hazard comparison.
// With REGFILE_CTRL_BYPASS_EN defined, o_ord_data also exposes entry data for forwarding.
module wbuf_fifo
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  i_push,
   input  wbuf_entry_t                           i_entry,
   input  logic                                  i_pop,
   output wbuf_entry_t                           o_head,
   output logic                                  o_full,
   output logic                                  o_empty,
   output logic [DEPTH-1:0][REG_ADDR_W-1:0]      o_ord_addr,
   output logic [DEPTH-1:0]                      o_ord_vld
`ifdef REGFILE_CTRL_BYPASS_EN
   ,output logic [DEPTH-1:0][REG_DATA_W-1:0]     o_ord_data
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   wbuf_entry_t   r_mem [DEPTH];

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_head  = r_mem[r_rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides which entries are live
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_entry;
   end

   // Age-ordered view of the buffer, oldest first
   always_comb begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
         o_ord_addr[k] = r_mem[r_rd_ptr + AW'(k)].addr;
         o_ord_vld[k]  = (CW'(k) < r_count);
`ifdef REGFILE_CTRL_BYPASS_EN
         o_ord_data[k] = r_mem[r_rd_ptr + AW'(k)].data;
`endif
      end
   end

endmodule

// File: rtl/regfile_ctrl.sv
// regfile_ctrl: arbitrates one register-file access per cycle between buffered
// writebacks and operand reads.
// Ports: clk, rst_n (async active-low), bus (regfile_ctrl_if.slave): wr_* writeback
// request, rd_* operand read request, rsp_* read response one cycle after acceptance,
// rf_* register-file port (combinational read, write on rf_ld).
// Macro REGFILE_CTRL_BYPASS_EN: reads are not stalled by pending writes; the youngest
// matching buffered/incoming write data is forwarded into the response instead.
module regfile_ctrl
   import regfile_pkg::*;
#(
   parameter int unsigned WBUF_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   regfile_ctrl_if.slave bus
);

   rf_state_e   w_state;
   wbuf_entry_t w_head;
   wbuf_entry_t w_in_entry;
   logic        w_full;
   logic        w_empty;
   logic        w_push;
   logic        w_pop;
   logic        w_wr_ready;
   logic        w_hazard;
   logic        w_starved;
   logic        w_rd_ready;
   logic        w_rf_ld;
   logic [REG_ADDR_W-1:0] w_rf_sa;
   logic [REG_ADDR_W-1:0] w_rf_sb;
   logic [REG_ADDR_W-1:0] w_rf_dr;
   logic [REG_DATA_W-1:0] w_rf_din;
   logic [REG_DATA_W-1:0] w_op_a;
   logic [REG_DATA_W-1:0] w_op_b;
   logic [WBUF_DEPTH-1:0][REG_ADDR_W-1:0] w_ord_addr;
   logic [WBUF_DEPTH-1:0]                 w_ord_vld;
`ifdef REGFILE_CTRL_BYPASS_EN
   logic [WBUF_DEPTH-1:0][REG_DATA_W-1:0] w_ord_data;
`endif

   logic [3:0]            r_starve;
   logic                  r_rsp_valid;
   logic [REG_DATA_W-1:0] r_rsp_a;
   logic [REG_DATA_W-1:0] r_rsp_b;

   // Writes to x0 are acknowledged but never stored
   assign w_wr_ready = rst_n & ~w_full;
   assign w_push     = bus.wr_valid & w_wr_ready & (bus.wr_addr != '0);
   assign w_in_entry = '{addr: bus.wr_addr, data: bus.wr_data};
   assign w_pop      = (w_state == ST_WR_GRANT);
   assign w_starved  = (r_starve == 4'(STARVE_MAX)) & ~w_empty;

   wbuf_fifo #(.DEPTH(WBUF_DEPTH)) u_wbuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push     (w_push),
      .i_entry    (w_in_entry),
      .i_pop      (w_pop),
      .o_head     (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_ord_addr (w_ord_addr),
      .o_ord_vld  (w_ord_vld)
`ifdef REGFILE_CTRL_BYPASS_EN
      ,.o_ord_data(w_ord_data)
`endif
   );

`ifdef REGFILE_CTRL_BYPASS_EN
   assign w_hazard = 1'b0;

   // Forwarding: scan oldest to youngest so the youngest match wins; the write being
   // accepted this cycle is younger than anything buffered
   always_comb begin
      w_op_a = bus.rf_data_a;
      w_op_b = bus.rf_data_b;
      for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
         if (w_ord_vld[k] && (w_ord_addr[k] == bus.rd_addr_a)) w_op_a = w_ord_data[k];
         if (w_ord_vld[k] && (w_ord_addr[k] == bus.rd_addr_b)) w_op_b = w_ord_data[k];
      end
      if (w_push && (bus.wr_addr == bus.rd_addr_a)) w_op_a = bus.wr_data;
      if (w_push && (bus.wr_addr == bus.rd_addr_b)) w_op_b = bus.wr_data;
      if (bus.rd_addr_a == '0) w_op_a = '0;
      if (bus.rd_addr_b == '0) w_op_b = '0;
   end
`else
   // Hazard: a nonzero operand address matches a buffered write or the write being
   // accepted this cycle (which would otherwise be overtaken by the read)
   always_comb begin
      w_hazard = 1'b0;
      for (int unsigned k = 0; k < WBUF_DEPTH; k++) begin
         if (w_ord_vld[k] && (bus.rd_addr_a != '0) && (w_ord_addr[k] == bus.rd_addr_a))
            w_hazard = 1'b1;
         if (w_ord_vld[k] && (bus.rd_addr_b != '0) && (w_ord_addr[k] == bus.rd_addr_b))
            w_hazard = 1'b1;
      end
      if (w_push && (bus.rd_addr_a != '0) && (bus.wr_addr == bus.rd_addr_a)) w_hazard = 1'b1;
      if (w_push && (bus.rd_addr_b != '0) && (bus.wr_addr == bus.rd_addr_b)) w_hazard = 1'b1;
   end

   assign w_op_a = (bus.rd_addr_a == '0) ? '0 : bus.rf_data_a;
   assign w_op_b = (bus.rd_addr_b == '0) ? '0 : bus.rf_data_b;
`endif

   // Grant selection: forced drain, then hazard-free read, then opportunistic drain
   always_comb begin
      w_state = ST_IDLE;
      if (!rst_n)                          w_state = ST_IDLE;
      else if (w_full || w_starved)        w_state = ST_WR_GRANT;
      else if (bus.rd_valid && !w_hazard)  w_state = ST_RD_GRANT;
      else if (!w_empty)                   w_state = ST_WR_GRANT;
   end

   // Register-file port drive for the granted access; all zero when idle
   always_comb begin
      w_rd_ready = 1'b0;
      w_rf_ld    = 1'b0;
      w_rf_sa    = '0;
      w_rf_sb    = '0;
      w_rf_dr    = '0;
      w_rf_din   = '0;
      case (w_state)
         ST_RD_GRANT: begin
            w_rd_ready = 1'b1;
            w_rf_sa    = bus.rd_addr_a;
            w_rf_sb    = bus.rd_addr_b;
         end
         ST_WR_GRANT: begin
            w_rf_ld  = 1'b1;
            w_rf_dr  = w_head.addr;
            w_rf_din = w_head.data;
         end
         default: ;
      endcase
   end

   // Starvation counter: reads granted while a write waits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve <= '0;
      end else if ((w_state == ST_WR_GRANT) || w_empty) begin
         r_starve <= '0;
      end else if ((w_state == ST_RD_GRANT) && (r_starve != 4'(STARVE_MAX))) begin
         r_starve <= r_starve + 4'd1;
      end
   end

   // Read response, captured at acceptance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_a     <= '0;
         r_rsp_b     <= '0;
      end else begin
         r_rsp_valid <= w_rd_ready;
         if (w_rd_ready) begin
            r_rsp_a <= w_op_a;
            r_rsp_b <= w_op_b;
         end
      end
   end

   assign bus.wr_ready   = w_wr_ready;
   assign bus.rd_ready   = w_rd_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data_a = r_rsp_a;
   assign bus.rsp_data_b = r_rsp_b;
   assign bus.rf_ld      = w_rf_ld;
   assign bus.rf_sa      = w_rf_sa;
   assign bus.rf_sb      = w_rf_sb;
   assign bus.rf_dr      = w_rf_dr;
   assign bus.rf_d_in    = w_rf_din;

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter WBUF_DEPTH, default 2, write-buffer entries, power of two, 2..8.
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive read grants allowed while writes wait, 1..15.
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST_N  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports WR_VALID in 1, WR_READY out 1, WR_ADDR in 5, WR_DATA in 32  writeback request channel.
REQ-006 SHALL have ports RD_VALID in 1, RD_READY out 1, RD_ADDR_A in 5, RD_ADDR_B in 5  operand read request channel.
REQ-007 SHALL have ports RSP_VALID out 1, RSP_DATA_A out 32, RSP_DATA_B out 32  read response, no backpressure.
REQ-008 SHALL have ports RF_LD out 1, RF_SA out 5, RF_SB out 5, RF_DR out 5, RF_D_IN out 32, RF_DATA_A in 32, RF_DATA_B in 32  register-file side.

Function
REQ-009 SHALL buffer accepted writes in a FIFO of WBUF_DEPTH entries; WR_READY = not full; no same-cycle pass-through when full.
REQ-010 SHALL accept but discard writes with WR_ADDR = 0 (x0 hardwired); they never enter the buffer.
REQ-011 SHALL grant at most one register-file access per cycle: read (RF_LD=0) or write (RF_LD=1).
REQ-012 SHALL run FSM states IDLE, RD_GRANT, WR_GRANT, evaluated each cycle with priority: WR_GRANT if buffer full or starve count = STARVE_MAX; else RD_GRANT if RD_VALID and no hazard; else WR_GRANT if buffer non-empty; else IDLE.
REQ-013 SHALL assert RD_READY only in cycles where RD_GRANT is selected; accepted read drives RF_SA/RF_SB same cycle.
REQ-014 SHALL assert RSP_VALID exactly one cycle after read acceptance, for one cycle, with RSP_DATA_A/B from RF_DATA_A/B; back-to-back reads give back-to-back responses.
REQ-015 SHALL return 0 on any operand whose read address is 0, regardless of RF data.
REQ-016 SHALL, in WR_GRANT, pop the FIFO head onto RF_DR/RF_D_IN with RF_LD=1 for one cycle.
REQ-017 SHALL detect a hazard when a nonzero RD_ADDR_A or RD_ADDR_B matches any buffered write address; with bypass disabled the read stalls until no match remains.
REQ-018 SHALL keep a 4-bit starve counter: increment (saturating at STARVE_MAX) on RD_GRANT with buffer non-empty, clear on WR_GRANT or empty buffer.
REQ-019 SHALL drive RF_LD=0, RF_SA/RF_SB/RF_DR=0, RF_D_IN=0 in IDLE.
REQ-020 SHALL, on a same-cycle enqueue and dequeue, keep occupancy unchanged and ordering preserved.

Reset
REQ-021 SHALL, while RST_N=0, hold RSP_VALID=0, RSP_DATA_A/B=0, RF_LD=0, RF_SA/SB/DR=0, RF_D_IN=0, WR_READY=0, RD_READY=0, FSM=IDLE, starve count=0, FIFO empty.
REQ-022 SHALL, on reset mid-operation, discard buffered writes and any in-flight response; first cycle after release WR_READY=1.

Configuration
REQ-023 SHALL compile read bypass under macro REGFILE_CTRL_BYPASS_EN.
REQ-024 SHALL, with REGFILE_CTRL_BYPASS_EN defined, not stall on hazard: at acceptance capture the youngest matching buffered data per operand and substitute it in the response.
REQ-025 SHALL, without REGFILE_CTRL_BYPASS_EN, stall per REQ-017 and contain no forwarding logic.

Structure
REQ-026 SHALL take REG_ADDR_W=5, REG_DATA_W=32 and the FSM state enum from shared package regfile_pkg.
REQ-027 SHALL implement the write buffer as sub-module wbuf_fifo (push/pop/full/empty, entry-address visibility for hazard compare).

Verification
REQ-028 SHALL cover: write x5=0xDEADBEEF, buffer drained, read A=5 B=0 -> RSP_VALID next cycle, A=0xDEADBEEF, B=0.
REQ-029 SHALL cover: fill buffer (2 writes) with RD_VALID held high -> WR_GRANT forced, RD_READY low until a slot frees.
REQ-030 SHALL cover: write x3=0x11 buffered, read A=3 same cycle -> without bypass stall until drained then 0x11; with bypass accepted immediately, A=0x11.
REQ-031 SHALL cover: RD_VALID continuous, one write pending -> write granted after exactly STARVE_MAX read grants.
REQ-032 SHALL cover: write x0=0xFFFFFFFF then read A=0 -> RF_LD never asserted for it, A=0.
REQ-033 SHALL cover: RST_N low with 2 buffered writes and a read in flight -> RSP_VALID=0, no RF_LD after release, FIFO empty.
